lcd_write_engine: RTL and testbench

//  Responder side of the sequencer's wr_enable/wr_finish handshake. Accepts one byte
//  (command or data) plus an RS flag, drives it onto an HD44780-style 4-bit LCD bus
//  (high nibble first, then low nibble), holds off for the controller's execution time,

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_delay_cnt.sv | 42 ++++
 rtl/lcd_write_engine.sv | 170 +++++++++++++++++
 tb/tb_lcd_write_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared state encoding and HD44780 command constants
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_E_HI  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_EXEC  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and home are the only instructions needing the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_delay_cnt.sv
// ============================================================================
// lcd_delay_cnt : loadable down-counter, expires while holding the value 1
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lcd_delay_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_1ms,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_1ms or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with T on entry, so a state lasts exactly T cycles.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/lcd_write_engine.sv
// ============================================================================
// lcd_write_engine : byte write onto a 4-bit HD44780 bus with E strobing,
//                    execution wait and wr_enable/wr_finish handshake
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int T_SETUP     = 1,
    parameter int T_E_HIGH    = 1,
    parameter int T_HOLD      = 1,
    parameter int T_EXEC      = 1,
    parameter int T_EXEC_LONG = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk_1ms,
    input  logic       reset_n,
    input  logic       wr_enable,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic       init_nibble,
    output logic       wr_finish,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    logic [2:0]       state_q,  state_d;
    logic             rs_q,     rs_d;
    logic [7:0]       data_q,   data_d;
    logic             init_q,   init_d;
    logic             nib_hi_q, nib_hi_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [3:0]       lcd_db_q, lcd_db_d;
    logic             lcd_e_q;
    logic             wr_finish_q;
    logic             busy_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_expire;
    logic [CNT_W-1:0] exec_len;

    lcd_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .clk_1ms  (clk_1ms),
        .reset_n  (reset_n),
        .load_i   (cnt_load),
        .value_i  (cnt_value),
        .expire_o (cnt_expire)
    );

    assign exec_len = is_long_cmd(rs_q, data_q) ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC);

    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        data_d    = data_q;
        init_d    = init_q;
        nib_hi_d  = nib_hi_q;
        cnt_load  = 1'b0;
        cnt_value = '0;

        case (state_q)
            ST_IDLE: begin
                if (wr_enable) begin
                    rs_d      = wr_rs;
                    data_d    = wr_data;
                    init_d    = init_nibble;
                    nib_hi_d  = 1'b1;
                    state_d   = ST_SETUP;
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(T_SETUP);
                end
            end
            ST_SETUP: begin
                if (cnt_expire) begin
                    state_d   = ST_E_HI;
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(T_E_HIGH);
                end
            end
            ST_E_HI: begin
                if (cnt_expire) begin
                    state_d   = ST_HOLD;
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(T_HOLD);
                end
            end
            ST_HOLD: begin
                if (cnt_expire) begin
                    cnt_load = 1'b1;
                    if (nib_hi_q && !init_q) begin
                        nib_hi_d  = 1'b0;
                        state_d   = ST_SETUP;
                        cnt_value = CNT_W'(T_SETUP);
                    end else begin
                        state_d   = ST_EXEC;
                        cnt_value = exec_len;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_expire) begin
                    state_d   = ST_DONE;
                    cnt_load  = 1'b1;
                    cnt_value = CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                cnt_load = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus only changes on SETUP entry; it keeps the last nibble through IDLE.
    always_comb begin
        lcd_rs_d = lcd_rs_q;
        lcd_db_d = lcd_db_q;
        if (state_d == ST_SETUP) begin
            lcd_rs_d = rs_d;
            lcd_db_d = nib_hi_d ? data_d[7:4] : data_d[3:0];
        end
    end

    always_ff @(posedge clk_1ms or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_q      <= 1'b0;
            nib_hi_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_db_q    <= 4'h0;
            lcd_e_q     <= 1'b0;
            wr_finish_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_q      <= init_d;
            nib_hi_q    <= nib_hi_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_db_q    <= lcd_db_d;
            lcd_e_q     <= (state_d == ST_E_HI);
            wr_finish_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign wr_finish = wr_finish_q;
    assign busy      = busy_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_db    = lcd_db_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_engine.sv
// ============================================================================
// tb_lcd_write_engine : two engines (default and slow timing) sharing one
//                       request stream, compared cycle by cycle to a model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_lcd_write_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_enable;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       init_nibble;

    logic [1:0] fin;
    logic [1:0] busy;
    logic [1:0] e;
    logic [1:0] rs;
    logic [1:0] rw;
    logic [3:0] db0;
    logic [3:0] db1;
    logic [8:0] dut_v [2];

    always #5 clk = ~clk;

    lcd_write_engine u_fast (
        .clk_1ms     (clk),
        .reset_n     (reset_n),
        .wr_enable   (wr_enable),
        .wr_rs       (wr_rs),
        .wr_data     (wr_data),
        .init_nibble (init_nibble),
        .wr_finish   (fin[0]),
        .busy        (busy[0]),
        .lcd_e       (e[0]),
        .lcd_rs      (rs[0]),
        .lcd_rw      (rw[0]),
        .lcd_db      (db0)
    );

    lcd_write_engine #(
        .T_SETUP     (3),
        .T_E_HIGH    (5),
        .T_HOLD      (2),
        .T_EXEC      (10),
        .T_EXEC_LONG (2),
        .CNT_W       (8)
    ) u_slow (
        .clk_1ms     (clk),
        .reset_n     (reset_n),
        .wr_enable   (wr_enable),
        .wr_rs       (wr_rs),
        .wr_data     (wr_data),
        .init_nibble (init_nibble),
        .wr_finish   (fin[1]),
        .busy        (busy[1]),
        .lcd_e       (e[1]),
        .lcd_rs      (rs[1]),
        .lcd_rw      (rw[1]),
        .lcd_db      (db1)
    );

    // Packed view: {e, rs, rw, db[3:0], busy, finish}
    assign dut_v[0] = {e[0], rs[0], rw[0], db0, busy[0], fin[0]};
    assign dut_v[1] = {e[1], rs[1], rw[1], db1, busy[1], fin[1]};

    int P_TS  [2] = '{1, 3};
    int P_TE  [2] = '{1, 5};
    int P_TH  [2] = '{1, 2};
    int P_TX  [2] = '{1, 10};
    int P_TXL [2] = '{2, 2};

    bit         m_act  [2];
    int         m_k    [2];
    logic       m_rs   [2];
    logic [7:0] m_d    [2];
    logic       m_init [2];
    logic       m_lrs  [2];
    logic [3:0] m_ldb  [2];
    logic [8:0] m_exp  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Total cycles of a transfer, acceptance period through the finish period.
    function automatic int xlen(int i, logic r, logic [7:0] d, logic ini);
        int nn = ini ? 1 : 2;
        int ex = (!r && (d == 8'h01 || d == 8'h02)) ? P_TXL[i] : P_TX[i];
        return nn * (P_TS[i] + P_TE[i] + P_TH[i]) + ex + 1;
    endfunction

    // Expected pins in the k-th cycle (1-based) of a transfer.
    function automatic logic [8:0] xexp(int i, int k, logic r, logic [7:0] d, logic ini);
        int         per = P_TS[i] + P_TE[i] + P_TH[i];
        int         nn  = ini ? 1 : 2;
        int         ph  = k - 1;
        logic       ee;
        logic [3:0] nb;
        if (ph < nn * per) begin
            ee = ((ph % per) >= P_TS[i]) && ((ph % per) < P_TS[i] + P_TE[i]);
            nb = (ph / per == 0) ? d[7:4] : d[3:0];
        end else begin
            ee = 1'b0;
            nb = (nn == 1) ? d[7:4] : d[3:0];
        end
        return {ee, r, 1'b0, nb, 1'b1, (k == xlen(i, r, d, ini))};
    endfunction

    task automatic model_reset(int i);
        m_act[i] = 1'b0;
        m_k[i]   = 0;
        m_lrs[i] = 1'b0;
        m_ldb[i] = 4'h0;
        m_exp[i] = '0;
    endtask

    task automatic model_step(int i);
        if (!reset_n) begin
            model_reset(i);
        end else begin
            if (m_act[i] && m_k[i] == xlen(i, m_rs[i], m_d[i], m_init[i])) begin
                m_act[i] = 1'b0;
            end else if (!m_act[i] && wr_enable) begin
                m_act[i]  = 1'b1;
                m_k[i]    = 0;
                m_rs[i]   = wr_rs;
                m_d[i]    = wr_data;
                m_init[i] = init_nibble;
            end
            if (m_act[i]) begin
                m_k[i]   = m_k[i] + 1;
                m_exp[i] = xexp(i, m_k[i], m_rs[i], m_d[i], m_init[i]);
                m_lrs[i] = m_rs[i];
                m_ldb[i] = m_exp[i][5:2];
            end else begin
                m_exp[i] = {1'b0, m_lrs[i], 1'b0, m_ldb[i], 2'b00};
            end
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: model advances with the inputs the DUTs sample, compare, then
    // return at the falling edge so the caller can drive the next inputs.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pins{e,rs,rw,db,busy,fin} inst%0d", i), 32'(dut_v[i]), 32'(m_exp[i]));
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(int i);
        int b = 0;
        while (busy[i] !== 1'b0 && b < 400) begin
            step();
            b++;
        end
        if (b >= 400) check($sformatf("idle timeout inst%0d", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic measure(int i, logic r, logic [7:0] d, logic ini, int exp_lat, string name);
        int n;
        wait_idle(i);
        wr_enable   = 1'b1;
        wr_rs       = r;
        wr_data     = d;
        init_nibble = ini;
        step();
        wr_enable   = 1'b0;
        wr_data     = 8'($urandom);
        wr_rs       = 1'($urandom);
        init_nibble = 1'($urandom);
        n = 1;
        while (fin[i] !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        int n;
        int nf;
        for (int i = 0; i < 2; i++) model_reset(i);
        reset_n     = 1'b0;
        wr_enable   = 1'b0;
        wr_rs       = 1'b0;
        wr_data     = 8'h00;
        init_nibble = 1'b0;

        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset finish", 32'(fin), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        check("model len data41", 32'(xlen(0, 1'b1, 8'h41, 1'b0)), 32'd8);
        check("model len clear", 32'(xlen(0, 1'b0, 8'h01, 1'b0)), 32'd9);
        check("model len data01", 32'(xlen(0, 1'b1, 8'h01, 1'b0)), 32'd8);
        check("model len init30", 32'(xlen(0, 1'b0, 8'h30, 1'b1)), 32'd5);
        check("model len slow", 32'(xlen(1, 1'b1, 8'h41, 1'b0)), 32'd31);

        measure(0, 1'b1, 8'h41, 1'b0, 8, "latency data41");
        measure(0, 1'b0, 8'h01, 1'b0, 9, "latency clear");
        measure(0, 1'b1, 8'h01, 1'b0, 8, "latency data01");
        measure(0, 1'b0, 8'h02, 1'b0, 9, "latency home");
        measure(0, 1'b0, 8'h30, 1'b1, 5, "latency init30");
        measure(1, 1'b1, 8'h41, 1'b0, 31, "latency slow");
        measure(1, 1'b0, 8'h01, 1'b0, 23, "latency slow clear");

        // Level-held request: back-to-back transfers with one idle cycle between.
        wait_idle(0);
        wr_enable   = 1'b1;
        wr_rs       = 1'b1;
        init_nibble = 1'b0;
        wr_data     = 8'h5A;
        nf          = 0;
        for (int c = 0; c < 27; c++) begin
            step();
            if (fin[0] === 1'b1) nf++;
            wr_data = 8'($urandom);
        end
        check("held enable finish count", 32'(nf), 32'd3);
        wr_enable = 1'b0;

        // Abort in E_HI.
        wait_idle(0);
        wait_idle(1);
        wr_enable = 1'b1;
        wr_rs     = 1'b1;
        wr_data   = 8'h41;
        step();
        wr_enable = 1'b0;
        n = 0;
        while (e[0] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("reach E high", 32'(e[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async reset lcd_e", 32'(e), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) model_reset(i);
        step();
        reset_n = 1'b1;
        nf = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (fin[0] === 1'b1) nf++;
        end
        check("no finish after abort", 32'(nf), 32'd0);

        // Random traffic with clear/home commands and init nibbles mixed in.
        for (int c = 0; c < 400; c++) begin
            wr_enable   = ($urandom_range(0, 2) == 0);
            wr_rs       = 1'($urandom);
            wr_data     = ($urandom_range(0, 3) == 0) ? 8'(8'h01 + $urandom_range(0, 1))
                                                      : 8'($urandom);
            init_nibble = ($urandom_range(0, 7) == 0);
            step();
        end
        wr_enable = 1'b0;
        wait_idle(0);
        wait_idle(1);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
